// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg
//  Types and constants shared by the inter-stage pipeline register.
//  - pstage_t      : occupancy state of a stage (empty / main / main+skid)
//  - OCC_*         : encoding of the 2-bit occupancy output
//  - DEFAULT_CNT_W : default width of the stall/bubble counters
//  - occ_of()      : maps a state to its occupancy encoding
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } pstage_t;

    localparam logic [1:0] OCC_NONE = 2'd0;
    localparam logic [1:0] OCC_ONE  = 2'd1;
    localparam logic [1:0] OCC_TWO  = 2'd2;

    localparam int DEFAULT_CNT_W = 16;

    function automatic logic [1:0] occ_of(input pstage_t s);
        logic [1:0] occ;
        case (s)
            ST_FULL:    occ = OCC_ONE;
            ST_SKIDDED: occ = OCC_TWO;
            default:    occ = OCC_NONE;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot
//  One register slot of a pipeline stage: a control bundle that can be
//  squashed to zero and a data bundle that is only ever overwritten.
// Ports
//  CLK, RST     clock, asynchronous active-high reset (clears both bundles)
//  load         capture d_ctrl/d_data this edge
//  clear_ctrl   force the held control bundle to zero, data held; wins over load
//  d_ctrl/d_data  incoming bundles
//  q_ctrl/q_data  held bundles
module pipe_slot
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 192
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clear_ctrl) begin
            // Squash turns the held entry into a NOP; data is left stale.
            ctrl_d = '0;
        end else if (load) begin
            ctrl_d = d_ctrl;
            data_d = d_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign q_ctrl = ctrl_q;
    assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//  Inter-stage pipeline register with valid/ready handshake, optional
//  one-entry skid slot (SKID=1) so that in_ready comes straight from a flop,
//  synchronous flush, and saturating stall/bubble counters.
// Ports
//  CLK, RST              clock, asynchronous active-high reset
//  flush                 squash everything held this edge
//  in_valid/in_ready     upstream handshake; in_ctrl/in_data upstream bundles
//  out_valid/out_ready   downstream handshake; out_ctrl (zero when invalid), out_data
//  occupancy             entries held (0..2)
//  stall_cnt             cycles with out_valid & !out_ready (saturating)
//  bubble_cnt            cycles with !out_valid & out_ready (saturating)
module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 192,
    parameter int SKID   = 1,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pstage_t state_q, state_d;

    logic              main_load, skid_load, take_skid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_src;
    logic [DATA_W-1:0] main_data, skid_data, main_data_src;

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = occ_of(state_q);

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        take_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    main_load = 1'b1;
                    state_d   = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (in_valid) main_load = 1'b1;
                    else          state_d   = ST_EMPTY;
                end else if (in_valid && SKID == 1) begin
                    // Downstream stalled but we already advertised ready:
                    // park the incoming entry behind the main one.
                    skid_load = 1'b1;
                    state_d   = ST_SKIDDED;
                end
            end
            ST_SKIDDED: begin
                if (out_ready) begin
                    main_load = 1'b1;
                    take_skid = 1'b1;
                    state_d   = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush beats any handshake: whatever was accepted this cycle is dropped.
        if (flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
            take_skid = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    assign main_ctrl_src = take_skid ? skid_ctrl : in_ctrl;
    assign main_data_src = take_skid ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .CLK        (CLK),
        .RST        (RST),
        .load       (main_load),
        .clear_ctrl (flush),
        .d_ctrl     (main_ctrl_src),
        .d_data     (main_data_src),
        .q_ctrl     (main_ctrl),
        .q_data     (main_data)
    );

    generate
        if (SKID == 1) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .CLK        (CLK),
                .RST        (RST),
                .load       (skid_load),
                .clear_ctrl (flush),
                .d_ctrl     (in_ctrl),
                .d_data     (in_data),
                .q_ctrl     (skid_ctrl),
                .q_data     (skid_data)
            );
            // Depends only on the state flop, so no combinational path from out_ready.
            assign in_ready = (state_q != ST_SKIDDED);
        end else begin : g_noskid
            assign skid_ctrl = '0;
            assign skid_data = '0;
            assign in_ready  = out_ready | ~out_valid;
        end
    endgenerate

    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = main_data;

    // Counter 0: stall, counter 1: bubble. Both saturate at all-ones.
    logic             cnt_inc [2];
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = out_valid & ~out_ready;
    assign cnt_inc[1] = ~out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_ONE;
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign stall_cnt  = cnt_val[0];
    assign bubble_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives a SKID=1 stage (A) and a SKID=0 stage (B) with the same stimulus.
// Each stage is modelled as a bounded FIFO (depth 2 / depth 1) held in a queue.
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_occ;
    logic [15:0]   a_stall, a_bubble;

    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occ;
    logic [7:0]    b_stall, b_bubble;

    int tests = 0;
    int failed = 0;

    ent_t qa[$];
    ent_t qb[$];
    int   sa = 0, ba = 0, sb = 0, bb = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(8)) dut_b (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs already applied: compare,
    // then advance both models across the next posedge.
    task automatic tick();
        logic ra, rb, pop_a, pop_b, push_a, push_b;
        ent_t ha, hb;
        #1;
        ha = '0;
        hb = '0;
        if (qa.size() != 0) ha = qa[0];
        if (qb.size() != 0) hb = qb[0];
        ra = (qa.size() < 2);
        rb = out_ready || (qb.size() == 0);

        chk("a_in_ready",  {31'd0, a_in_ready},  {31'd0, ra});
        chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, qa.size() != 0});
        chk("a_out_ctrl",  {24'd0, a_out_ctrl},  {24'd0, ha.c});
        if (qa.size() != 0) chk("a_out_data", {16'd0, a_out_data}, {16'd0, ha.d});
        chk("a_occupancy", {30'd0, a_occ}, qa.size());
        chk("a_stall_cnt", {16'd0, a_stall}, sa);
        chk("a_bubble_cnt", {16'd0, a_bubble}, ba);

        chk("b_in_ready",  {31'd0, b_in_ready},  {31'd0, rb});
        chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, qb.size() != 0});
        chk("b_out_ctrl",  {24'd0, b_out_ctrl},  {24'd0, hb.c});
        if (qb.size() != 0) chk("b_out_data", {16'd0, b_out_data}, {16'd0, hb.d});
        chk("b_occupancy", {30'd0, b_occ}, qb.size());
        chk("b_stall_cnt", {24'd0, b_stall}, sb);
        chk("b_bubble_cnt", {24'd0, b_bubble}, bb);

        pop_a  = (qa.size() != 0) && out_ready;
        pop_b  = (qb.size() != 0) && out_ready;
        push_a = in_valid && ra;
        push_b = in_valid && rb;
        if (pop_a) $display("[TB] A deliver ctrl=%0h data=%0h", ha.c, ha.d);
        if (pop_b) $display("[TB] B deliver ctrl=%0h data=%0h", hb.c, hb.d);

        if (qa.size() != 0 && !out_ready && sa < 65535) sa++;
        if (qa.size() == 0 && out_ready && ba < 65535) ba++;
        if (qb.size() != 0 && !out_ready && sb < 255) sb++;
        if (qb.size() == 0 && out_ready && bb < 255) bb++;

        @(posedge CLK);
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (pop_a) void'(qa.pop_front());
            if (pop_b) void'(qb.pop_front());
            if (push_a) qa.push_back({in_ctrl, in_data});
            if (push_b) qb.push_back({in_ctrl, in_data});
        end
        @(negedge CLK);
    endtask

    task automatic send(input logic v, input logic [DW-1:0] val);
        in_valid = v;
        in_ctrl  = val[CW-1:0];
        in_data  = val;
        tick();
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
        chk("rst_out_data",  {16'd0, a_out_data},  32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Streaming 1..8 with downstream always ready.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) send(1'b1, DW'(k));
        send(1'b0, '0);
        send(1'b0, '0);

        // Backpressure: 1,2,3 with downstream stalled, then release.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(1'b1, DW'(k));
        chk("bp_occ_two", {30'd0, a_occ}, 32'd2);
        out_ready = 1'b1;
        repeat (4) send(1'b1, 16'd3);
        send(1'b0, '0);

        // Flush while skidded, with a new entry offered in the same cycle.
        out_ready = 1'b0;
        send(1'b1, 16'h11);
        send(1'b1, 16'h22);
        flush = 1'b1;
        send(1'b1, 16'hAA);
        flush = 1'b0;
        out_ready = 1'b1;
        send(1'b0, '0);
        send(1'b0, '0);

        // Alternating downstream ready with continuous input.
        for (int i = 0; i < 16; i++) begin
            out_ready = (i % 2 == 0);
            send(1'b1, DW'(16'h100 + i));
        end

        // Randomised traffic including occasional flushes.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            send($urandom_range(0, 3) != 0, DW'($urandom));
        end
        flush = 1'b0;

        // Reset asserted with both stages holding data.
        out_ready = 1'b0;
        send(1'b1, 16'h55);
        send(1'b1, 16'h66);
        RST = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("midrst_out_ctrl",  {24'd0, a_out_ctrl},  32'd0);
        chk("midrst_occ",       {30'd0, a_occ},       32'd0);
        chk("midrst_stall",     {16'd0, a_stall},     32'd0);
        chk("midrst_bubble",    {16'd0, a_bubble},    32'd0);
        chk("midrst_b_valid",   {31'd0, b_out_valid}, 32'd0);
        qa.delete();
        qb.delete();
        sa = 0; ba = 0; sb = 0; bb = 0;
        @(negedge CLK);
        RST = 1'b0;
        in_valid = 1'b0;

        // Long bubble run: B's 8-bit counter must stop at all-ones.
        out_ready = 1'b1;
        repeat (300) send(1'b0, '0);
        chk("b_bubble_sat", {24'd0, b_bubble}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
